store_rmw_ctrl: RTL and testbench

- Sequences sub-word stores to a word-wide data memory as read-modify-write, and word stores as a direct write.
- Sits between the execute/LSU stage and the data-memory port. It performs the byte/half-word lane merge itself, honouring the address byte offset, so it is the sequential consumer of the store-merge function.
- Accepts one store at a time over a valid/ready handshake and reports completion or error with single-cycle pulses.

---
 rtl/store_rmw_ctrl.sv | 147 ++++++++++++++
 tb/tb_store_rmw_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_rmw_ctrl.sv
// Store sequencer: word stores write directly, sub-word stores
// read the word, merge the byte/half lanes, then write it back.
module store_rmw_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_type,
  output logic              st_done,
  output logic              st_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE, ERR
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [1:0]  off_q;
  logic        byte_q;
  logic [15:0] data_q;
  logic [15:0] cnt_q;
  logic        misalign;
  logic        accept;
  logic        timeout;
  logic [31:0] merged;

  assign accept  = st_valid && (state == IDLE);
  assign timeout = (cnt_q == 16'(TIMEOUT_CYC - 1));

  // alignment rule per store width
  always_comb begin
    misalign = 1'b0;
    unique case (1'b1)
      st_type == 2'd1: misalign = st_addr[0];
      st_type == 2'd2: misalign = |st_addr[1:0];
      default:         misalign = 1'b0;
    endcase
  end

  // lane merge of latched store data into the returned word
  always_comb begin
    merged = mem_rdata;
    if (byte_q) begin
      unique case (off_q)
        2'd0: merged[7:0]   = data_q[7:0];
        2'd1: merged[15:8]  = data_q[7:0];
        2'd2: merged[23:16] = data_q[7:0];
        default: merged[31:24] = data_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merged[31:16] = data_q;
    end else begin
      merged[15:0] = data_q;
    end
  end

  // next state and state-decoded outputs
  always_comb begin
    state_nx = state;
    st_ready = 1'b0;
    st_done  = 1'b0;
    st_err   = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    unique case (state)
      IDLE: begin
        st_ready = 1'b1;
        if (st_valid) begin
          if (misalign)              state_nx = ERR;
          else if (st_type == 2'd3) state_nx = DONE;
          else if (st_type == 2'd2) state_nx = WR_REQ;
          else                       state_nx = RD_REQ;
        end
      end
      RD_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid)   state_nx = WR_REQ;
        else if (timeout) state_nx = ERR;
      end
      WR_REQ: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_gnt) state_nx = DONE;
      end
      DONE: begin
        st_done  = 1'b1;
        state_nx = IDLE;
      end
      ERR: begin
        st_err   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // request capture, wait counter, memory address/data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q     <= '0;
      byte_q    <= 1'b0;
      data_q    <= '0;
      cnt_q     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (accept) begin
        off_q  <= st_addr[1:0];
        byte_q <= (st_type == 2'd0);
        data_q <= st_data[15:0];
        if (!misalign && st_type != 2'd3)
          mem_addr <= {st_addr[ADDR_W-1:2], 2'b00};
        if (!misalign && st_type == 2'd2)
          mem_wdata <= st_data;
      end
      if (state == RD_REQ && mem_gnt)
        cnt_q <= '0;
      if (state == RD_WAIT) begin
        cnt_q <= cnt_q + 16'd1;
        if (mem_rvalid) mem_wdata <= merged;
      end
    end
  end

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Randomized bench for store_rmw_ctrl with a per-cycle
// timeline model and a word-addressed memory model.
module tb_store_rmw_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid, st_ready;
  logic [31:0] st_addr, st_data;
  logic [1:0]  st_type;
  logic        st_done, st_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  store_rmw_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data),
    .st_type(st_type), .st_done(st_done),
    .st_err(st_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int passes = 0;
  int n_rd = 0;
  int n_wr = 0;
  logic [31:0] last_wa, last_wd;

  logic        e_on = 1'b0;
  logic        e_ready, e_req, e_we, e_done, e_err;
  logic [31:0] e_addr = '0;
  logic [31:0] e_wdata = '0;

  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [31:0] merge(
    input logic [31:0] r, input logic [1:0] typ,
    input logic [1:0] off, input logic [31:0] d);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = r[8*i +: 8];
    b[int'(off)] = d[7:0];
    if (typ == 2'd1) b[int'(off) + 1] = d[15:8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // compare outputs and log granted traffic
  always @(negedge clk) begin
    if (rst_n && mem_req && mem_gnt) begin
      if (mem_we) begin
        n_wr++;
        last_wa = mem_addr;
        last_wd = mem_wdata;
      end else begin
        n_rd++;
      end
    end
    if (e_on) begin
      chk("ctl", {27'b0, st_ready, mem_req, mem_we,
                  st_done, st_err},
                 {27'b0, e_ready, e_req, e_we,
                  e_done, e_err});
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic r, q, w, d, e);
    e_ready = r; e_req = q; e_we = w;
    e_done = d; e_err = e; e_on = 1'b1;
  endtask

  task automatic noise();
    mem_gnt    = 1'($urandom);
    mem_rvalid = 1'($urandom);
    mem_rdata  = $urandom;
  endtask

  task automatic junk_st();
    st_valid = 1'($urandom);
    st_addr  = $urandom;
    st_data  = $urandom;
    st_type  = 2'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      st_valid = 1'b0;
      noise();
      ex(1, 0, 0, 0, 0);
      nxt();
    end
  endtask

  task automatic wr_phase(input int gd);
    for (int i = 0; i <= gd; i++) begin
      junk_st();
      mem_gnt    = (i == gd);
      mem_rvalid = 1'($urandom);
      mem_rdata  = $urandom;
      ex(0, 1, 1, 0, 0);
      nxt();
    end
    junk_st();
    noise();
    ex(0, 0, 0, 1, 0);
    nxt();
  endtask

  // one store: accept, then drive memory per chosen delays
  task automatic run(input logic [1:0] typ,
                     input logic [31:0] addr,
                     input logic [31:0] data,
                     input int gd1, input int rv,
                     input int gd2);
    logic [31:0] wa;
    logic        mis;
    logic [31:0] r;
    int          rd0, wr0;
    int          erd, ewr;
    wa  = {addr[31:2], 2'b00};
    mis = (typ == 2'd1 && addr[0]) ||
          (typ == 2'd2 && addr[1:0] != 2'b00);
    rd0 = n_rd;
    wr0 = n_wr;
    erd = (!mis && typ < 2'd2) ? 1 : 0;
    ewr = (!mis && (typ == 2'd2 ||
          (typ < 2'd2 && rv <= TO))) ? 1 : 0;
    st_valid = 1'b1;
    st_addr  = addr;
    st_data  = data;
    st_type  = typ;
    noise();
    ex(1, 0, 0, 0, 0);
    nxt();
    if (mis) begin
      junk_st(); noise();
      ex(0, 0, 0, 0, 1);
      nxt();
    end else if (typ == 2'd3) begin
      junk_st(); noise();
      ex(0, 0, 0, 1, 0);
      nxt();
    end else if (typ == 2'd2) begin
      e_addr  = wa;
      e_wdata = data;
      mem[wa] = data;
      wr_phase(gd2);
    end else begin
      e_addr = wa;
      if (!mem.exists(wa)) mem[wa] = $urandom;
      r = mem[wa];
      for (int i = 0; i <= gd1; i++) begin
        junk_st();
        mem_gnt    = (i == gd1);
        mem_rvalid = 1'($urandom);
        mem_rdata  = $urandom;
        ex(0, 1, 0, 0, 0);
        nxt();
      end
      for (int k = 1; k <= TO; k++) begin
        junk_st();
        mem_gnt = 1'($urandom);
        ex(0, 0, 0, 0, 0);
        if (k == rv) begin
          mem_rvalid = 1'b1;
          mem_rdata  = r;
          nxt();
          e_wdata = merge(r, typ, addr[1:0], data);
          mem[wa] = e_wdata;
          wr_phase(gd2);
          break;
        end
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        nxt();
        if (k == TO) begin
          junk_st(); noise();
          ex(0, 0, 0, 0, 1);
          nxt();
        end
      end
    end
    chk("reads", n_rd - rd0, erd);
    chk("writes", n_wr - wr0, ewr);
  endtask

  task automatic reset_mid();
    int w0;
    w0 = n_wr;
    st_valid = 1'b1;
    st_addr  = 32'h400;
    st_data  = 32'h12345678;
    st_type  = 2'd2;
    mem_gnt  = 1'b0;
    ex(1, 0, 0, 0, 0);
    nxt();
    st_valid = 1'b0;
    mem_gnt  = 1'b0;
    e_on     = 1'b0;
    chk("wr_req", {31'b0, mem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_ready", {31'b0, st_ready}, 32'd1);
    e_addr  = '0;
    e_wdata = '0;
    nxt();
    ex(1, 0, 0, 0, 0);
    nxt();
    rst_n = 1'b1;
    nxt();
    chk("rst_nowr", n_wr - w0, 0);
  endtask

  initial begin
    rst_n      = 1'b1;
    st_valid   = 1'b0;
    st_addr    = '0;
    st_data    = '0;
    st_type    = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    #1 rst_n = 1'b0;
    ex(1, 0, 0, 0, 0);
    repeat (3) nxt();
    rst_n = 1'b1;
    idle(2);

    mem[32'h100] = 32'h11223344;
    run(2'd0, 32'h102, 32'h000000AB, 0, 1, 0);
    chk("byte_wa", last_wa, 32'h100);
    chk("byte_wd", last_wd, 32'h11AB3344);

    mem[32'h204] = 32'hCAFEF00D;
    run(2'd1, 32'h206, 32'h0000BEEF, 0, 1, 0);
    chk("half_hi", last_wd, 32'hBEEFF00D);
    mem[32'h204] = 32'hCAFEF00D;
    run(2'd1, 32'h204, 32'h0000BEEF, 0, 1, 0);
    chk("half_lo", last_wd, 32'hCAFEBEEF);

    run(2'd2, 32'h300, 32'hDEADBEEF, 0, 1, 0);
    chk("word_wd", last_wd, 32'hDEADBEEF);
    run(2'd1, 32'h301, 32'h1234, 0, 1, 0);
    run(2'd2, 32'h302, 32'h1234, 0, 1, 0);

    run(2'd0, 32'h101, 32'h77, 5, 2, 5);

    run(2'd1, 32'h202, 32'h5555, 0, TO + 1, 0);
    idle(1);
    run(2'd1, 32'h202, 32'h5555, 0, TO, 0);

    reset_mid();
    run(2'd0, 32'h503, 32'hC3, 1, 2, 1);
    run(2'd3, 32'h600, 32'h0, 0, 1, 0);

    for (int n = 0; n < 150; n++) begin
      logic [1:0]  t;
      logic [31:0] a;
      int          rv;
      t  = 2'($urandom_range(0, 3));
      a  = 32'h1000 + 32'($urandom_range(0, 7) * 4)
                    + 32'($urandom_range(0, 3));
      rv = ($urandom_range(0, 5) == 0) ? TO + 1
                                       : $urandom_range(1, TO);
      run(t, a, $urandom, $urandom_range(0, 3), rv,
          $urandom_range(0, 3));
      idle($urandom_range(0, 2));
    end

    e_on = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
